// File: rtl/bridge_pkg.sv
// Shared state encoding, default widths and gate-drive constants for bridge_pulse_seq.
// ST_QDLY exists only when BRIDGE_QUAR_DELAY_EN is defined.
package bridge_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DT_W   = 6;
    localparam int unsigned NCYC_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAD,
        ST_POS,
        ST_NEG,
`ifdef BRIDGE_QUAR_DELAY_EN
        ST_QDLY,
`endif
        ST_TAIL
    } state_t;

    // Bit order: q1q8, q2q7, q3q6, q4q5
    typedef logic [3:0] drv_t;

    localparam drv_t DRV_OFF = 4'b0000;
    localparam drv_t DRV_POS = 4'b1001;
    localparam drv_t DRV_NEG = 4'b0110;

endpackage

// File: rtl/bridge_dead_timer.sv
// Loadable dead-time down-counter shared by the DEAD and TAIL phases of bridge_pulse_seq.
module bridge_dead_timer #(
    parameter int unsigned DT_W = bridge_pkg::DT_W
) (
    input  logic            clk_sys,
    input  logic            rst,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    output logic            expired
);

    logic [DT_W-1:0] count;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - DT_W'(1);
        end
    end

    // Flags the edge that completes the loaded number of cycles.
    assign expired = (count <= DT_W'(1));

endmodule

// File: rtl/bridge_pulse_seq.sv
// H-bridge transmit-pulse sequencer: dead-time separated positive/negative halves for a burst.
// Optional quarter-period start delay (quar_delay input, QDLY state) under BRIDGE_QUAR_DELAY_EN.
module bridge_pulse_seq #(
    parameter int unsigned CNT_W  = bridge_pkg::CNT_W,
    parameter int unsigned DT_W   = bridge_pkg::DT_W,
    parameter int unsigned NCYC_W = bridge_pkg::NCYC_W
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              para_load,
    input  logic [CNT_W-1:0]  half_para,
    input  logic [DT_W-1:0]   dead_para,
    input  logic [NCYC_W-1:0] cycle_num,
    input  logic              start,
    input  logic              phase,
    input  logic              abort,
`ifdef BRIDGE_QUAR_DELAY_EN
    input  logic              quar_delay,
`endif
    output logic              q1q8,
    output logic              q2q7,
    output logic              q3q6,
    output logic              q4q5,
    output logic              up,
    output logic              down,
    output logic              bri_cycle,
    output logic              busy,
    output logic              done
);

    import bridge_pkg::*;

    state_t            state;
    drv_t              drv;
    logic [CNT_W-1:0]  half_sh;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  half_len;
    logic [DT_W-1:0]   dead_sh;
    logic [DT_W-1:0]   dead_len;
    logic [NCYC_W-1:0] ncyc_sh;
    logic [NCYC_W-1:0] ccnt;
    logic              toggle;
    logic              second;
    logic              idle;
    logic              go;
    logic              tick_last;
    logic              half_exit;
    logic              tmr_load;
    logic              tmr_expired;

    assign half_len  = (half_sh == '0) ? CNT_W'(1) : half_sh;
    assign dead_len  = (dead_sh == '0) ? DT_W'(1) : dead_sh;
    assign idle      = (state == ST_IDLE);
    assign go        = idle && start && !abort && (ncyc_sh != '0);
    assign tick_last = clk_en && (hcnt <= CNT_W'(1));
    assign half_exit = ((state == ST_POS) || (state == ST_NEG)) && tick_last;

`ifdef BRIDGE_QUAR_DELAY_EN
    logic [CNT_W-1:0] quar_len;
    logic             qdly_exit;

    assign quar_len  = ((half_sh >> 1) == '0) ? CNT_W'(1) : (half_sh >> 1);
    assign qdly_exit = (state == ST_QDLY) && tick_last;
    assign tmr_load  = (go && !quar_delay) || half_exit || qdly_exit;
`else
    assign tmr_load  = go || half_exit;
`endif

    bridge_dead_timer #(
        .DT_W(DT_W)
    ) u_dead_timer (
        .clk_sys (clk_sys),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(dead_len),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drv       <= DRV_OFF;
            half_sh   <= '0;
            dead_sh   <= '0;
            ncyc_sh   <= '0;
            hcnt      <= '0;
            ccnt      <= '0;
            toggle    <= 1'b0;
            second    <= 1'b0;
            up        <= 1'b0;
            down      <= 1'b0;
            bri_cycle <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            up        <= 1'b0;
            down      <= 1'b0;
            bri_cycle <= 1'b0;
            done      <= 1'b0;

            if (para_load && idle) begin
                half_sh <= half_para;
                dead_sh <= dead_para;
                ncyc_sh <= cycle_num;
            end

            // Abort outranks start and every expiry in the same cycle.
            if (abort && !idle) begin
                state <= ST_IDLE;
                drv   <= DRV_OFF;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (ncyc_sh == '0) begin
                                done <= 1'b1;
                            end else begin
                                busy   <= 1'b1;
                                toggle <= phase;
                                second <= 1'b0;
                                ccnt   <= ncyc_sh;
`ifdef BRIDGE_QUAR_DELAY_EN
                                if (quar_delay) begin
                                    state <= ST_QDLY;
                                    hcnt  <= quar_len;
                                end else begin
                                    state <= ST_DEAD;
                                end
`else
                                state  <= ST_DEAD;
`endif
                            end
                        end
                    end
`ifdef BRIDGE_QUAR_DELAY_EN
                    ST_QDLY: begin
                        if (tick_last) begin
                            state <= ST_DEAD;
                        end else if (clk_en) begin
                            hcnt <= hcnt - CNT_W'(1);
                        end
                    end
`endif
                    ST_DEAD: begin
                        if (tmr_expired) begin
                            hcnt <= half_len;
                            if (toggle) begin
                                state <= ST_NEG;
                                drv   <= DRV_NEG;
                                down  <= 1'b1;
                            end else begin
                                state <= ST_POS;
                                drv   <= DRV_POS;
                                up    <= 1'b1;
                            end
                        end
                    end
                    ST_POS, ST_NEG: begin
                        if (half_exit) begin
                            drv    <= DRV_OFF;
                            toggle <= ~toggle;
                            second <= ~second;
                            if (second) begin
                                bri_cycle <= 1'b1;
                                ccnt      <= ccnt - NCYC_W'(1);
                                state     <= (ccnt == NCYC_W'(1)) ? ST_TAIL : ST_DEAD;
                            end else begin
                                state <= ST_DEAD;
                            end
                        end else if (clk_en) begin
                            hcnt <= hcnt - CNT_W'(1);
                        end
                    end
                    ST_TAIL: begin
                        if (tmr_expired) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        drv   <= DRV_OFF;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q1q8 = drv[3];
    assign q2q7 = drv[2];
    assign q3q6 = drv[1];
    assign q4q5 = drv[0];

endmodule

// File: tb/tb_bridge_pulse_seq.sv
// Scoreboard bench for bridge_pulse_seq: a burst-level timeline model predicts every output event.
// Exercises the quarter-delay path when BRIDGE_QUAR_DELAY_EN is defined.
module tb_bridge_pulse_seq;

    localparam int CNT_W  = 8;
    localparam int DT_W   = 6;
    localparam int NCYC_W = 16;

    localparam int K_DRV  = 0;
    localparam int K_BUSY = 1;
    localparam int K_UP   = 2;
    localparam int K_DOWN = 3;
    localparam int K_CYC  = 4;
    localparam int K_DONE = 5;

    logic              clk_sys = 1'b0;
    logic              rst;
    logic              clk_en;
    logic              para_load;
    logic [CNT_W-1:0]  half_para;
    logic [DT_W-1:0]   dead_para;
    logic [NCYC_W-1:0] cycle_num;
    logic              start;
    logic              phase;
    logic              abort;
`ifdef BRIDGE_QUAR_DELAY_EN
    logic              quar_delay;
`endif
    logic q1q8, q2q7, q3q6, q4q5, up, down, bri_cycle, busy, done;

    typedef struct {
        int kind;
        int val;
        int edge_no;
    } ev_t;

    ev_t exp_q[$];
    ev_t plan[$];
    int  pos_entry[$];
    int  total = 0;
    int  bad = 0;
    int  ecount = 0;
    int  period = 2;
    int  abort_at = -1;
    int  sh_h = 0;
    int  sh_d = 0;
    int  sh_n = 0;

    bridge_pulse_seq #(
        .CNT_W (CNT_W),
        .DT_W  (DT_W),
        .NCYC_W(NCYC_W)
    ) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .clk_en    (clk_en),
        .para_load (para_load),
        .half_para (half_para),
        .dead_para (dead_para),
        .cycle_num (cycle_num),
        .start     (start),
        .phase     (phase),
        .abort     (abort),
`ifdef BRIDGE_QUAR_DELAY_EN
        .quar_delay(quar_delay),
`endif
        .q1q8      (q1q8),
        .q2q7      (q2q7),
        .q3q6      (q3q6),
        .q4q5      (q4q5),
        .up        (up),
        .down      (down),
        .bri_cycle (bri_cycle),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_sys = ~clk_sys;

    // ecount == n means edge n has just happened
    always @(posedge clk_sys) ecount <= ecount + 1;

    // clk_en is high at edge n iff n % period == 0; abort is high at edge abort_at
    initial begin
        clk_en = 1'b0;
        abort  = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            clk_en = ((ecount + 1) % period == 0);
            abort  = (ecount + 1 == abort_at);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, edge=%0d", ecount);
        $fatal(1, "watchdog");
    end

    function automatic int nth_tick(input int t, input int n);
        int e = t;
        int c = 0;
        while (c < n) begin
            e++;
            if (e % period == 0) c++;
        end
        return e;
    endfunction

    task automatic add_ev(input int kind, input int val, input int e);
        ev_t x;
        x.kind = kind;
        x.val = val;
        x.edge_no = e;
        plan.push_back(x);
    endtask

    // Timeline of a whole burst started at edge s, truncated by an abort at edge ab (ab < 0: none)
    task automatic build(input int s, input bit ph, input bit qd, input int ab);
        int   he, de, t, last_drv;
        bit   tog;
        ev_t  kept[$];
        plan.delete();
        pos_entry.delete();
        he = (sh_h == 0) ? 1 : sh_h;
        de = (sh_d == 0) ? 1 : sh_d;
        if (sh_n == 0) begin
            add_ev(K_DONE, 1, s);
            return;
        end
        add_ev(K_BUSY, 1, s);
        t = s;
        if (qd) t = nth_tick(t, ((sh_h / 2) == 0) ? 1 : sh_h / 2);
        tog = ph;
        for (int c = 0; c < sh_n; c++) begin
            for (int k = 0; k < 2; k++) begin
                t = t + de;
                add_ev(K_DRV, tog ? 6 : 9, t);
                add_ev(tog ? K_DOWN : K_UP, 1, t);
                if (!tog) pos_entry.push_back(t);
                t = nth_tick(t, he);
                add_ev(K_DRV, 0, t);
                if (k == 1) add_ev(K_CYC, 1, t);
                tog = !tog;
            end
        end
        t = t + de;
        add_ev(K_BUSY, 0, t);
        add_ev(K_DONE, 1, t);
        if (ab >= 0) begin
            last_drv = 0;
            foreach (plan[i]) begin
                if (plan[i].edge_no < ab) begin
                    kept.push_back(plan[i]);
                    if (plan[i].kind == K_DRV) last_drv = plan[i].val;
                end
            end
            plan = kept;
            if (last_drv != 0) add_ev(K_DRV, 0, ab);
            add_ev(K_BUSY, 0, ab);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got kind=%0d val=%0d edge=%0d, want none", kind, val, ecount);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.edge_no != ecount) begin
                bad++;
                $display("FAIL event got kind=%0d val=%0d edge=%0d want kind=%0d val=%0d edge=%0d",
                         kind, val, ecount, e.kind, e.val, e.edge_no);
            end
        end
    endtask

    task automatic monitor();
        logic [3:0] d;
        logic [3:0] prev_d;
        logic       prev_b;
        prev_d = '0;
        prev_b = 1'b0;
        forever begin
            @(negedge clk_sys);
            d = {q1q8, q2q7, q3q6, q4q5};
            if (rst) begin
                prev_d = '0;
                prev_b = 1'b0;
            end else begin
                total++;
                if ((d[3] | d[0]) & (d[2] | d[1])) begin
                    bad++;
                    $display("FAIL drive_overlap got=%b want no pos/neg overlap edge=%0d", d, ecount);
                end
                if (d != prev_d) check_ev(K_DRV, int'(d));
                if (busy != prev_b) check_ev(K_BUSY, int'(busy));
                if (up) check_ev(K_UP, 1);
                if (down) check_ev(K_DOWN, 1);
                if (bri_cycle) check_ev(K_CYC, 1);
                if (done) check_ev(K_DONE, 1);
                prev_d = d;
                prev_b = busy;
            end
        end
    endtask

    task automatic do_load(input int h, input int d, input int n);
        @(posedge clk_sys);
        #1;
        para_load = 1'b1;
        half_para = CNT_W'(h);
        dead_para = DT_W'(d);
        cycle_num = NCYC_W'(n);
        @(posedge clk_sys);
        #1;
        para_load = 1'b0;
        sh_h = h;
        sh_d = d;
        sh_n = n;
    endtask

    // ab_mode: 0 none, 1 abort two edges into the second POS, 2 abort at a random edge of the burst
    task automatic start_burst(input bit ph, input bit qd, input int ab_mode);
        int s, ab;
        @(posedge clk_sys);
        #1;
        s = ecount + 1;
        build(s, ph, qd, -1);
        ab = -1;
        if (ab_mode == 1 && pos_entry.size() > 1) ab = pos_entry[1] + 2;
        else if (ab_mode == 2 && sh_n != 0) ab = int'($urandom_range(plan[plan.size()-1].edge_no, s + 1));
        if (ab >= 0) begin
            build(s, ph, qd, ab);
            abort_at = ab;
        end
        foreach (plan[i]) exp_q.push_back(plan[i]);
        start = 1'b1;
        phase = ph;
`ifdef BRIDGE_QUAR_DELAY_EN
        quar_delay = qd;
`endif
        @(posedge clk_sys);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk_sys);
            n++;
        end
        repeat (4) @(posedge clk_sys);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d after %0d cycles, want 0", exp_q.size(), n);
            exp_q.delete();
        end
        abort_at = -1;
    endtask

    task automatic run_tests();
        int n;
        bit qd_r;
        repeat (3) @(posedge clk_sys);
        #1;
        check_val("reset_outputs", int'({q1q8, q2q7, q3q6, q4q5, up, down, bri_cycle, busy, done}), 0);
        @(negedge clk_sys);
        rst = 1'b0;

        // shadows are zero after reset, so a bare start completes at once
        start_burst(1'b0, 1'b0, 0);
        drain();

        period = 2;
        do_load(4, 2, 2);
        start_burst(1'b0, 1'b0, 0);
        drain();

        period = 3;
        do_load(3, 0, 1);
        start_burst(1'b1, 1'b0, 0);
        drain();

        do_load(5, 1, 0);
        start_burst(1'b0, 1'b0, 0);
        drain();

        period = 2;
        do_load(4, 2, 3);
        start_burst(1'b0, 1'b0, 1);
        drain();

        // abort with start while idle: nothing may happen
        do_load(2, 1, 1);
        @(posedge clk_sys);
        #1;
        abort_at = ecount + 2;
        @(posedge clk_sys);
        #1;
        start = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        drain();

        // para_load and start during a burst are dropped
        period = 1;
        do_load(4, 1, 1);
        start_burst(1'b0, 1'b0, 0);
        repeat (3) @(posedge clk_sys);
        #1;
        para_load = 1'b1;
        half_para = CNT_W'(9);
        start = 1'b1;
        phase = 1'b1;
        @(posedge clk_sys);
        #1;
        para_load = 1'b0;
        start = 1'b0;
        drain();
        start_burst(1'b0, 1'b0, 0);
        drain();
        do_load(9, 1, 1);
        start_burst(1'b1, 1'b0, 0);
        drain();

`ifdef BRIDGE_QUAR_DELAY_EN
        period = 2;
        do_load(6, 2, 1);
        start_burst(1'b0, 1'b1, 0);
        drain();
`endif

        for (int i = 0; i < 10; i++) begin
            qd_r = 1'b0;
`ifdef BRIDGE_QUAR_DELAY_EN
            qd_r = 1'($urandom_range(1, 0));
`endif
            period = int'($urandom_range(3, 1));
            do_load(int'($urandom_range(6, 0)), int'($urandom_range(4, 0)), int'($urandom_range(3, 0)));
            start_burst(1'($urandom_range(1, 0)), qd_r, ($urandom_range(2, 0) == 0) ? 2 : 0);
            drain();
        end

        // asynchronous reset while a positive half is driving
        period = 1;
        do_load(4, 1, 2);
        start_burst(1'b0, 1'b0, 0);
        n = 0;
        while (ecount < pos_entry[0] + 1 && n < 500) begin
            @(posedge clk_sys);
            n++;
        end
        @(negedge clk_sys);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_reset_outputs", int'({q1q8, q2q7, q3q6, q4q5, busy}), 0);
        exp_q.delete();
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b0;
        sh_h = 0;
        sh_d = 0;
        sh_n = 0;
        start_burst(1'b0, 1'b0, 0);
        drain();
    endtask

    initial begin
        rst = 1'b1;
        para_load = 1'b0;
        start = 1'b0;
        phase = 1'b0;
        half_para = '0;
        dead_para = '0;
        cycle_num = '0;
`ifdef BRIDGE_QUAR_DELAY_EN
        quar_delay = 1'b0;
`endif
        fork
            monitor();
            run_tests();
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
